// File: rtl/mio_data_responder.sv
// Data-side memory/IO responder: word RAM, LED/switch/counter registers,
// fixed wait states and a single MIO_ready pulse per transaction.
module mio_data_responder #(
    parameter int RAM_ADDR_BITS = 10,
    parameter int WAIT_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_request,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_writeData,
    input  logic [15:0] switch_in,
    output logic        MIO_ready,
    output logic [31:0] mem_readData,
    output logic        mem_addressError,
    output logic [15:0] led_out
);

    localparam int         DEPTH     = 1 << RAM_ADDR_BITS;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] led_q, led_d;
    logic [31:0] cyc_q, cyc_d;

    logic [31:0] ram [DEPTH];
    logic        ram_we;

    logic        access;
    logic        acc_wr;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        sel_ram, sel_led, sel_sw, sel_cyc;
    logic        acc_err;
    logic [RAM_ADDR_BITS-1:0] ram_idx;

    // Zero wait states access straight from the bus in IDLE.
    always_comb begin
        acc_wr    = (state_q == IDLE) ? mem_write     : wr_q;
        acc_addr  = (state_q == IDLE) ? mem_address   : addr_q;
        acc_wdata = (state_q == IDLE) ? mem_writeData : wdata_q;
        ram_idx   = acc_addr[RAM_ADDR_BITS+1:2];
        sel_ram   = (acc_addr >> (RAM_ADDR_BITS + 2)) == 32'd0;
        sel_led   = acc_addr == 32'hFFFF_FF00;
        sel_sw    = acc_addr == 32'hFFFF_FF04;
        sel_cyc   = acc_addr == 32'hFFFF_FF08;
        acc_err   = (acc_addr[1:0] != 2'b00) ||
                    !(sel_ram || sel_led || sel_sw || sel_cyc);
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_request) begin
                    wr_d    = mem_write;
                    addr_d  = mem_address;
                    wdata_d = mem_writeData;
                    wait_d  = WAIT_INIT;
                    if (WAIT_INIT == 4'd0) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_d = access;
        rdata_d = rdata_q;
        err_d   = err_q;
        led_d   = led_q;
        cyc_d   = cyc_q + 32'd1;
        ram_we  = 1'b0;
        if (access) begin
            err_d   = acc_err;
            rdata_d = 32'd0;
            if (!acc_err) begin
                if (acc_wr) begin
                    unique case (1'b1)
                        sel_ram: ram_we = 1'b1;
                        sel_led: led_d  = acc_wdata[15:0];
                        sel_cyc: cyc_d  = acc_wdata;
                        default: ;
                    endcase
                end else begin
                    unique case (1'b1)
                        sel_ram: rdata_d = ram[ram_idx];
                        sel_led: rdata_d = {16'h0, led_q};
                        sel_sw:  rdata_d = {16'h0, switch_in};
                        sel_cyc: rdata_d = cyc_q;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            led_q   <= 16'd0;
            cyc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            led_q   <= led_d;
            cyc_q   <= cyc_d;
        end
    end

    // RAM has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= acc_wdata;
        end
    end

    assign MIO_ready        = ready_q;
    assign mem_readData     = rdata_q;
    assign mem_addressError = err_q;
    assign led_out          = led_q;

endmodule

// File: tb/tb_mio_data_responder.sv
// Directed bench for mio_data_responder: W=2 main instance plus a W=0
// instance for the back-to-back throughput check.
module tb_mio_data_responder;

    localparam int W = 2;

    logic        clk;
    logic        rst_n;
    logic        req, wr;
    logic [31:0] addr, wdata;
    logic [15:0] sw_in;
    logic        ready, err;
    logic [31:0] rdata;
    logic [15:0] led;

    logic        req0;
    logic        ready0, err0;
    logic [31:0] rdata0;
    logic [15:0] led0;

    int n_checks;
    int n_fail;

    mio_data_responder #(.RAM_ADDR_BITS(10), .WAIT_CYCLES(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_request      (req),
        .mem_write        (wr),
        .mem_address      (addr),
        .mem_writeData    (wdata),
        .switch_in        (sw_in),
        .MIO_ready        (ready),
        .mem_readData     (rdata),
        .mem_addressError (err),
        .led_out          (led)
    );

    mio_data_responder #(.RAM_ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_request      (req0),
        .mem_write        (1'b0),
        .mem_address      (32'hFFFF_FF04),
        .mem_writeData    (32'd0),
        .switch_in        (sw_in),
        .MIO_ready        (ready0),
        .mem_readData     (rdata0),
        .mem_addressError (err0),
        .led_out          (led0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Call just after a rising edge; returns just after the edge that
    // follows the response cycle, with the request dropped.
    task automatic txn(input logic w, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic e, output int lat);
        int c;
        c   = 0;
        lat = -1;
        rd  = 32'hx;
        e   = 1'bx;
        req = 1'b1; wr = w; addr = a; wdata = d;
        while (c < 20) begin
            @(negedge clk);
            if (ready) begin
                lat = c;
                rd  = rdata;
                e   = err;
                break;
            end
            @(posedge clk); #1;
            c++;
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
        req0 = 1'b0; sw_in = 16'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready got %b want 0", ready);
        end
        n_checks++;
        if (rdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_rdata got %h want 0", rdata);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err got %b want 0", err);
        end
        n_checks++;
        if (led !== 16'd0) begin
            n_fail++; $display("FAIL reset_led got %h want 0", led);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ram();
        logic [31:0] rd;
        logic        e;
        int          lat;
        txn(1'b1, 32'h10, 32'h1234_5678, rd, e, lat);
        n_checks++;
        if (lat !== W + 1) begin
            n_fail++; $display("FAIL sw_latency got %0d want %0d", lat, W + 1);
        end
        n_checks++;
        if (e !== 1'b0) begin
            n_fail++; $display("FAIL sw_err got %b want 0", e);
        end
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL ready_one_cycle got %b want 0", ready);
        end
        @(posedge clk); #1;
        txn(1'b0, 32'h10, 32'h0, rd, e, lat);
        n_checks++;
        if (lat !== W + 1) begin
            n_fail++; $display("FAIL lw_latency got %0d want %0d", lat, W + 1);
        end
        n_checks++;
        if (rd !== 32'h1234_5678) begin
            n_fail++; $display("FAIL lw_data got %h want 12345678", rd);
        end
        txn(1'b1, 32'h20, 32'h0, rd, e, lat);
        txn(1'b1, 32'h0, 32'hCAFE_0000, rd, e, lat);
    endtask

    task automatic test_back_to_back();
        req0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (ready0 !== logic'(i % 2)) begin
                n_fail++;
                $display("FAIL b2b_ready cyc %0d got %b want %0d",
                         i, ready0, i % 2);
            end
            @(posedge clk); #1;
        end
        req0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_led_switch();
        logic [31:0] rd;
        logic        e;
        int          lat;
        txn(1'b1, 32'hFFFF_FF00, 32'hABCD_9876, rd, e, lat);
        n_checks++;
        if (led !== 16'h9876) begin
            n_fail++; $display("FAIL led_write got %h want 9876", led);
        end
        txn(1'b0, 32'hFFFF_FF00, 32'h0, rd, e, lat);
        n_checks++;
        if (rd !== 32'h0000_9876) begin
            n_fail++; $display("FAIL led_read got %h want 00009876", rd);
        end
        sw_in = 16'h00F0;
        txn(1'b0, 32'hFFFF_FF04, 32'h0, rd, e, lat);
        n_checks++;
        if (rd !== 32'h0000_00F0) begin
            n_fail++; $display("FAIL sw_read got %h want 000000F0", rd);
        end
        txn(1'b1, 32'hFFFF_FF04, 32'h5555_5555, rd, e, lat);
        n_checks++;
        if (e !== 1'b0) begin
            n_fail++; $display("FAIL sw_write_err got %b want 0", e);
        end
        n_checks++;
        if (led !== 16'h9876) begin
            n_fail++; $display("FAIL sw_write_led got %h want 9876", led);
        end
        txn(1'b0, 32'hFFFF_FF04, 32'h0, rd, e, lat);
        n_checks++;
        if (rd !== 32'h0000_00F0) begin
            n_fail++; $display("FAIL sw_reread got %h want 000000F0", rd);
        end
    endtask

    // Load lands on the write's access edge; the read edge comes W+3 edges
    // later and returns the pre-increment value: FFFFFFFE + W + 2.
    task automatic test_counter();
        logic [31:0] rd;
        logic        e;
        int          lat;
        logic [31:0] exp_cnt;
        exp_cnt = 32'hFFFF_FFFE + 32'(W + 2);
        txn(1'b1, 32'hFFFF_FF08, 32'hFFFF_FFFE, rd, e, lat);
        @(posedge clk); #1;
        txn(1'b0, 32'hFFFF_FF08, 32'h0, rd, e, lat);
        n_checks++;
        if (rd !== exp_cnt) begin
            n_fail++; $display("FAIL cnt_wrap got %h want %h", rd, exp_cnt);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        e;
        int          lat;
        txn(1'b0, 32'h0, 32'h0, rd, e, lat);
        n_checks++;
        if (rd !== 32'hCAFE_0000) begin
            n_fail++; $display("FAIL ram0_pre got %h want CAFE0000", rd);
        end
        txn(1'b0, 32'h6, 32'h0, rd, e, lat);
        n_checks++;
        if (e !== 1'b1) begin
            n_fail++; $display("FAIL misalign_err got %b want 1", e);
        end
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL misalign_data got %h want 0", rd);
        end
        n_checks++;
        if (lat !== W + 1) begin
            n_fail++; $display("FAIL err_latency got %0d want %0d", lat, W + 1);
        end
        txn(1'b1, 32'h8000_0000, 32'h1111_1111, rd, e, lat);
        n_checks++;
        if (e !== 1'b1) begin
            n_fail++; $display("FAIL unmapped_err got %b want 1", e);
        end
        n_checks++;
        if (led !== 16'h9876) begin
            n_fail++; $display("FAIL err_led got %h want 9876", led);
        end
        txn(1'b0, 32'h0, 32'h0, rd, e, lat);
        n_checks++;
        if (rd !== 32'hCAFE_0000 || e !== 1'b0) begin
            n_fail++; $display("FAIL ram0_post got %h/%b want CAFE0000/0", rd, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          seen;
        seen = 0;
        req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst_n = 1'b0;
        req   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready === 1'b1) seen++;
            if (i == 2) rst_n = 1'b1;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL abort_ready got %0d pulses want 0", seen);
        end
        n_checks++;
        if (led !== 16'd0) begin
            n_fail++; $display("FAIL abort_led got %h want 0", led);
        end
        @(posedge clk); #1;
        txn(1'b0, 32'h20, 32'h0, rd, e, lat);
        n_checks++;
        if (rd !== 32'd0 || e !== 1'b0 || lat !== W + 1) begin
            n_fail++;
            $display("FAIL abort_read got %h/%b/%0d want 0/0/%0d",
                     rd, e, lat, W + 1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_ram();
        test_back_to_back();
        test_led_switch();
        test_counter();
        test_errors();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
